// File: rtl/mem_sp_arb_if.sv
// Bundle of both requester channels and the single-port memory side of mem_sp_arb.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface mem_sp_arb_if #(
    parameter int MEM_DATAWIDTH = 128,
    parameter int MEM_ADDRWIDTH = 14
);
    localparam int WEW = (MEM_DATAWIDTH + 7) / 8;

    logic                     a_req_valid;
    logic                     a_req_ready;
    logic [WEW-1:0]           a_req_we;
    logic [MEM_ADDRWIDTH-1:0] a_req_addr;
    logic [MEM_DATAWIDTH-1:0] a_req_wdata;
    logic                     a_rsp_valid;
    logic [MEM_DATAWIDTH-1:0] a_rsp_rdata;

    logic                     b_req_valid;
    logic                     b_req_ready;
    logic [WEW-1:0]           b_req_we;
    logic [MEM_ADDRWIDTH-1:0] b_req_addr;
    logic [MEM_DATAWIDTH-1:0] b_req_wdata;
    logic                     b_rsp_valid;
    logic [MEM_DATAWIDTH-1:0] b_rsp_rdata;

    logic                     mem_en;
    logic [WEW-1:0]           mem_we;
    logic [MEM_ADDRWIDTH-1:0] mem_addr;
    logic [MEM_DATAWIDTH-1:0] mem_din;
    logic [MEM_DATAWIDTH-1:0] mem_dout;

    modport slave (
        input  a_req_valid, a_req_we, a_req_addr, a_req_wdata,
        output a_req_ready, a_rsp_valid, a_rsp_rdata,
        input  b_req_valid, b_req_we, b_req_addr, b_req_wdata,
        output b_req_ready, b_rsp_valid, b_rsp_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output a_req_valid, a_req_we, a_req_addr, a_req_wdata,
        input  a_req_ready, a_rsp_valid, a_rsp_rdata,
        output b_req_valid, b_req_we, b_req_addr, b_req_wdata,
        input  b_req_ready, b_rsp_valid, b_rsp_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_sp_arb.sv
// Round-robin arbiter sharing one single-port memory between requesters A and B,
// routing each read response back to its issuer after READ_LATENCY cycles.
module mem_sp_arb #(
    parameter int MEM_DATAWIDTH = 128,
    parameter int MEM_ADDRWIDTH = 14,
    parameter int READ_LATENCY  = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_sp_arb_if.slave    bus
);
    localparam int WEW = (MEM_DATAWIDTH + 7) / 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e                   lastGrant_q, lastGrant_d;
    logic [READ_LATENCY-1:0] pipeValid_q, pipeValid_d;
    logic [READ_LATENCY-1:0] pipeIsB_q, pipeIsB_d;

    logic grantA;
    logic grantB;
    logic accepted;
    logic readAccepted;

    // On contention the port that did not win last time is granted.
    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (!reset) begin
            if (bus.a_req_valid && bus.b_req_valid) begin
                grantA = (lastGrant_q == PORT_B);
                grantB = (lastGrant_q == PORT_A);
            end else begin
                grantA = bus.a_req_valid;
                grantB = bus.b_req_valid;
            end
        end
    end

    assign accepted     = grantA | grantB;
    assign readAccepted = accepted && (bus.mem_we == '0);

    assign bus.a_req_ready = grantA;
    assign bus.b_req_ready = grantB;

    assign bus.mem_en   = accepted;
    assign bus.mem_we   = grantA ? bus.a_req_we : (grantB ? bus.b_req_we : {WEW{1'b0}});
    assign bus.mem_addr = grantB ? bus.b_req_addr  : bus.a_req_addr;
    assign bus.mem_din  = grantB ? bus.b_req_wdata : bus.a_req_wdata;

    always_comb begin
        lastGrant_d = lastGrant_q;
        if (grantA) begin
            lastGrant_d = PORT_A;
        end else if (grantB) begin
            lastGrant_d = PORT_B;
        end

        pipeValid_d    = pipeValid_q;
        pipeIsB_d      = pipeIsB_q;
        pipeValid_d[0] = readAccepted;
        pipeIsB_d[0]   = grantB;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipeValid_d[i] = pipeValid_q[i-1];
            pipeIsB_d[i]   = pipeIsB_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q <= PORT_B;
            pipeValid_q <= '0;
            pipeIsB_q   <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            pipeValid_q <= pipeValid_d;
            pipeIsB_q   <= pipeIsB_d;
        end
    end

    // Responses carry no backpressure; the last stage names the receiving port.
    assign bus.a_rsp_valid = !reset && pipeValid_q[READ_LATENCY-1] && !pipeIsB_q[READ_LATENCY-1];
    assign bus.b_rsp_valid = !reset && pipeValid_q[READ_LATENCY-1] &&  pipeIsB_q[READ_LATENCY-1];
    assign bus.a_rsp_rdata = bus.mem_dout;
    assign bus.b_rsp_rdata = bus.mem_dout;

endmodule

// File: tb/tb_mem_sp_arb.sv
// Directed bench for mem_sp_arb: one instance at read latency 1, one at latency 3,
// each in front of a small behavioural single-port memory.
module tb_mem_sp_arb;
    localparam int DW  = 128;
    localparam int AW  = 14;
    localparam int WEW = (DW + 7) / 8;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    logic memInit;
    int   testsRun    = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    mem_sp_arb_if #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW)) if1 ();
    mem_sp_arb_if #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW)) if3 ();

    mem_sp_arb #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW), .READ_LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1)
    );

    mem_sp_arb #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW), .READ_LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (if3)
    );

    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem3 [256];
    logic [DW-1:0] rd3s0;
    logic [DW-1:0] rd3s1;

    // Latency-1 memory with byte enables.
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem1[i] <= '0;
            mem1[1] <= 128'h1111;
            mem1[2] <= 128'h2222;
        end else if (if1.mem_en) begin
            if (if1.mem_we != '0) begin
                for (int j = 0; j < WEW; j++)
                    if (if1.mem_we[j]) mem1[if1.mem_addr[7:0]][j*8 +: 8] <= if1.mem_din[j*8 +: 8];
            end else begin
                if1.mem_dout <= mem1[if1.mem_addr[7:0]];
            end
        end
    end

    // Latency-3 memory: read data passes through two extra register stages.
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem3[i] <= '0;
            mem3[5] <= 128'h55;
            mem3[6] <= 128'h66;
            mem3[7] <= 128'h77;
        end else if (if3.mem_en && if3.mem_we == '0) begin
            rd3s0 <= mem3[if3.mem_addr[7:0]];
        end
        rd3s1        <= rd3s0;
        if3.mem_dout <= rd3s1;
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, then waits for the falling edge.
    task automatic applyStimulus(input logic rst,
                                 input logic av, input logic [WEW-1:0] awe, input logic [AW-1:0] aaddr, input logic [DW-1:0] awdata,
                                 input logic bv, input logic [WEW-1:0] bwe, input logic [AW-1:0] baddr, input logic [DW-1:0] bwdata);
        @(posedge clk);
        #1;
        rst1            = rst;
        if1.a_req_valid = av;
        if1.a_req_we    = awe;
        if1.a_req_addr  = aaddr;
        if1.a_req_wdata = awdata;
        if1.b_req_valid = bv;
        if1.b_req_we    = bwe;
        if1.b_req_addr  = baddr;
        if1.b_req_wdata = bwdata;
        @(negedge clk);
    endtask

    task automatic applyStimulus3(input logic rst, input logic av, input logic [AW-1:0] aaddr);
        @(posedge clk);
        #1;
        rst3            = rst;
        if3.a_req_valid = av;
        if3.a_req_addr  = aaddr;
        @(negedge clk);
    endtask

    initial begin
        logic prevA;
        rst1 = 1'b1;
        rst3 = 1'b1;
        memInit = 1'b1;
        if1.a_req_valid = 1'b0; if1.a_req_we = '0; if1.a_req_addr = '0; if1.a_req_wdata = '0;
        if1.b_req_valid = 1'b0; if1.b_req_we = '0; if1.b_req_addr = '0; if1.b_req_wdata = '0;
        if3.a_req_valid = 1'b0; if3.a_req_we = '0; if3.a_req_addr = '0; if3.a_req_wdata = '0;
        if3.b_req_valid = 1'b0; if3.b_req_we = '0; if3.b_req_addr = '0; if3.b_req_wdata = '0;
        @(posedge clk);
        #1;
        memInit = 1'b0;

        // Reset holds off a waiting requester.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, '0, 14'h0, '0, 0, '0, '0, '0);
            checkOutput("rst_a_ready", if1.a_req_ready, 0);
            checkOutput("rst_mem_en", if1.mem_en, 0);
        end
        applyStimulus(0, 1, '0, 14'h0, '0, 0, '0, '0, '0);
        checkOutput("post_rst_a_ready", if1.a_req_ready, 1);
        checkOutput("post_rst_mem_en", if1.mem_en, 1);

        // Write then read back through A.
        applyStimulus(0, 1, '1, 14'h10, 128'hDEAD_BEEF, 0, '0, '0, '0);
        checkOutput("rd0_a_rsp_valid", if1.a_rsp_valid, 1);
        checkOutput("rd0_a_rsp_rdata", if1.a_rsp_rdata, 0);
        checkOutput("wr_mem_we", if1.mem_we, {WEW{1'b1}});
        applyStimulus(0, 1, '0, 14'h10, '0, 0, '0, '0, '0);
        checkOutput("wr_no_rsp", if1.a_rsp_valid, 0);
        applyStimulus(0, 0, '0, '0, '0, 0, '0, '0, '0);
        checkOutput("rdA_rsp_valid", if1.a_rsp_valid, 1);
        checkOutput("rdA_rsp_rdata", if1.a_rsp_rdata, 128'hDEAD_BEEF);
        checkOutput("rdA_b_rsp_valid", if1.b_rsp_valid, 0);
        checkOutput("idle_mem_en", if1.mem_en, 0);
        applyStimulus(0, 0, '0, '0, '0, 0, '0, '0, '0);
        checkOutput("rdA_pulse_end", if1.a_rsp_valid, 0);

        // Byte write from B leaves the other bytes of a zeroed word untouched.
        applyStimulus(0, 0, '0, '0, '0, 1, 16'h0001, 14'h30, {{120{1'b1}}, 8'h5A});
        checkOutput("bw_b_ready", if1.b_req_ready, 1);
        checkOutput("bw_a_ready", if1.a_req_ready, 0);
        checkOutput("bw_mem_we", if1.mem_we, 16'h0001);
        applyStimulus(0, 0, '0, '0, '0, 1, '0, 14'h30, '0);
        checkOutput("br_mem_we", if1.mem_we, 0);
        applyStimulus(0, 0, '0, '0, '0, 0, '0, '0, '0);
        checkOutput("br_b_rsp_valid", if1.b_rsp_valid, 1);
        checkOutput("br_b_rsp_rdata", if1.b_rsp_rdata, 128'h5A);
        checkOutput("br_a_rsp_valid", if1.a_rsp_valid, 0);

        // Contention: last grant was B, so A wins first and grants alternate.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, '0, 14'h1, '0, 1, '0, 14'h2, '0);
            checkOutput($sformatf("cont%0d_a_ready", i), if1.a_req_ready, (i % 2 == 0));
            checkOutput($sformatf("cont%0d_b_ready", i), if1.b_req_ready, (i % 2 != 0));
            checkOutput($sformatf("cont%0d_addr", i), if1.mem_addr, (i % 2 == 0) ? 1 : 2);
            if (i > 0) begin
                prevA = ((i - 1) % 2 == 0);
                checkOutput($sformatf("cont%0d_a_rsp", i), if1.a_rsp_valid, prevA);
                checkOutput($sformatf("cont%0d_b_rsp", i), if1.b_rsp_valid, !prevA);
                if (prevA) checkOutput($sformatf("cont%0d_a_rdata", i), if1.a_rsp_rdata, 128'h1111);
                else       checkOutput($sformatf("cont%0d_b_rdata", i), if1.b_rsp_rdata, 128'h2222);
            end else begin
                checkOutput("cont0_no_rsp", if1.a_rsp_valid | if1.b_rsp_valid, 0);
            end
        end
        applyStimulus(0, 0, '0, '0, '0, 0, '0, '0, '0);
        checkOutput("cont_last_b_rsp", if1.b_rsp_valid, 1);
        checkOutput("cont_last_b_rdata", if1.b_rsp_rdata, 128'h2222);
        checkOutput("cont_last_a_rsp", if1.a_rsp_valid, 0);

        // Back-to-back writes never produce responses.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, '1, 14'h40 + 14'(i), 128'h100 + 128'(i), 0, '0, '0, '0);
            checkOutput($sformatf("wr%0d_mem_en", i), if1.mem_en, 1);
            checkOutput($sformatf("wr%0d_rsp", i), if1.a_rsp_valid | if1.b_rsp_valid, 0);
        end
        applyStimulus(0, 1, '0, 14'h42, '0, 0, '0, '0, '0);
        checkOutput("wr_after_rsp", if1.a_rsp_valid | if1.b_rsp_valid, 0);
        applyStimulus(0, 0, '0, '0, '0, 0, '0, '0, '0);
        checkOutput("wr_readback_valid", if1.a_rsp_valid, 1);
        checkOutput("wr_readback_data", if1.a_rsp_rdata, 128'h102);
        checkOutput("idle2_mem_we", if1.mem_we, 0);

        // Latency 3: reset while two reads are in flight drops both responses.
        applyStimulus3(0, 0, '0);
        applyStimulus3(0, 1, 14'h5);
        checkOutput("l3_rd1_ready", if3.a_req_ready, 1);
        applyStimulus3(0, 1, 14'h6);
        checkOutput("l3_rd2_ready", if3.a_req_ready, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus3(1, 0, '0);
            checkOutput($sformatf("l3_rst%0d_rsp", i), if3.a_rsp_valid, 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus3(0, 0, '0);
            checkOutput($sformatf("l3_drop%0d_rsp", i), if3.a_rsp_valid, 0);
        end
        applyStimulus3(0, 1, 14'h7);
        checkOutput("l3_rd3_ready", if3.a_req_ready, 1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus3(0, 0, '0);
            checkOutput($sformatf("l3_wait%0d_rsp", i), if3.a_rsp_valid, (i == 3));
            if (i == 3) checkOutput("l3_rdata", if3.a_rsp_rdata, 128'h77);
        end
        checkOutput("l3_b_rsp", if3.b_rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/mem_sp_arb.md
Name: mem_sp_arb

Overview:
- Two-requester arbiter for the single-port memory wrapper; shares one clocked SRAM/XPM port between requester A (core side) and requester B (NoC/DTU side).
- Round-robin grant on contention; valid/ready request handshake; read-response routing to the issuing requester after a fixed memory read latency.
- Sits directly in front of the single-port memory wrapper; its mem_* outputs connect one-to-one to the wrapper's en/we/addr/din/dout.

Parameters:
- MEM_DATAWIDTH, 128, data width of memory and both requesters.
- MEM_ADDRWIDTH, 14, word address width.
- READ_LATENCY, 1, cycles from mem_en (read) to valid mem_dout; legal range 1..4.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- a_req_valid  in  1  requester A request valid.
- a_req_ready  out  1  requester A request accepted this cycle.
- a_req_we  in  (MEM_DATAWIDTH+7)/8  byte write enables; all-zero means read.
- a_req_addr  in  MEM_ADDRWIDTH  word address.
- a_req_wdata  in  MEM_DATAWIDTH  write data.
- a_rsp_valid  out  1  read data valid for A (single-cycle pulse, no backpressure).
- a_rsp_rdata  out  MEM_DATAWIDTH  read data for A.
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: same directions, widths and meaning as the A ports, for requester B.
- mem_en  out  1  memory enable.
- mem_we  out  (MEM_DATAWIDTH+7)/8  memory byte write enables.
- mem_addr  out  MEM_ADDRWIDTH  memory address.
- mem_din  out  MEM_DATAWIDTH  memory write data.
- mem_dout  in  MEM_DATAWIDTH  memory read data, valid READ_LATENCY cycles after the read's mem_en.

Behaviour:
- Handshake: a request is accepted in a cycle where x_req_valid && x_req_ready. Requester holds valid and payload stable until accepted.
- Grant (combinational from registered state):
  - Exactly one requester is granted per cycle when any valid is present; x_req_ready = grant_x.
  - Only A valid -> A. Only B valid -> B.
  - Both valid -> the port not recorded in last_grant.
  - last_grant updates on every accepted request to the winning port. Reset value B, so A wins the first contention.
- Memory drive:
  - mem_en = accepted; mem_we/mem_addr/mem_din = granted port's payload.
  - mem_we is forced to 0 whenever mem_en = 0; mem_addr/mem_din are don't-care then.
- Throughput: one access per cycle; back-to-back accepts from the same port are allowed when the other port is idle.
- Read tracking:
  - Shift pipeline of READ_LATENCY stages, each holding {valid, port}.
  - Stage 0 is loaded with valid = accepted && (we == 0) and port = granted port.
  - When the last stage is valid, its port's x_rsp_valid = 1 and x_rsp_rdata = mem_dout. The other port's rsp_valid = 0.
  - Writes produce no response.
  - Response order per port equals request order.
- rsp_rdata of the non-responding port: don't-care. Tie both rdata outputs to mem_dout.
- Reset (synchronous, highest priority):
  - last_grant <- B; all pipeline valids <- 0.
  - While reset = 1: a_req_ready = b_req_ready = 0, mem_en = 0, mem_we = 0, a_rsp_valid = b_rsp_valid = 0.
  - Reads in flight when reset asserts are dropped; their responses are never emitted.
- Simultaneous events: a response emerging and a new accept in the same cycle are independent; both happen.
- No internal error conditions; addresses are not range-checked.

Test Plan:
- Reset then idle: reset = 1 for 3 cycles with a_req_valid = 1 -> a_req_ready = 0, mem_en = 0 throughout; first cycle after reset -> a_req_ready = 1, mem_en = 1.
- Single read A, READ_LATENCY = 1: write 0xDEAD_BEEF to addr 0x10 via A (we all ones), then read 0x10 via A -> a_rsp_valid pulses exactly 1 cycle after the read accept, a_rsp_rdata = 0xDEAD_BEEF, b_rsp_valid stays 0.
- Contention: A and B both valid continuously for 6 cycles, reads to addr 1 (A) and addr 2 (B) -> grant sequence A, B, A, B, A, B; responses routed to the matching port in the same order.
- Byte writes: B writes we = 0x0001, wdata byte0 = 0x5A to an addr preloaded with zero, then reads it -> b_rsp_rdata = 0x...005A with upper bytes 0.
- Latency 3 with reset mid-flight: READ_LATENCY = 3; A issues 2 reads, reset asserts 1 cycle after the second accept -> no a_rsp_valid ever emitted for either read; the next post-reset read responds after exactly 3 cycles.
- Write no-response: 4 back-to-back A writes -> mem_en high 4 cycles, a_rsp_valid and b_rsp_valid never assert.
